// File: rtl/sa_host_sequencer.sv
// Host-side sequencer for the bit-serial systolic matrix engine.
// Holds two NxN bit operand matrices and streams them as skewed byte pairs.
// Then drives readout, captures the N result rows, and pulses done.
module sa_host_sequencer #(
  parameter int unsigned N = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic                    i_usexor_cfg,
  input  logic                    i_wr_en,
  input  logic [$clog2(2*N)-1:0]  i_wr_addr,
  input  logic [N-1:0]            i_wr_data,
  input  logic [$clog2(N)-1:0]    i_rd_addr,
  output logic [N-1:0]            o_rd_data,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [7:0]              o_dev_ui_in,
  output logic                    o_dev_readout,
  output logic                    o_dev_usexor,
  output logic                    o_dev_sayhi,
  input  logic [7:0]              i_dev_uo_out
);

  localparam int unsigned PAIRS = 3 * N - 1;
  localparam int unsigned AW    = $clog2(2 * N);
  localparam int unsigned RW    = $clog2(N);
  localparam int unsigned CW    = $clog2(2 * PAIRS + 1);

  typedef enum logic [1:0] {StIdle, StStream, StRead, StDone} state_e;

  state_e          r_state;
  state_e          w_state_d;
  logic [CW-1:0]   r_cnt;
  logic            r_usexor;
  logic [N-1:0]    r_p   [N];
  logic [N-1:0]    r_q   [N];
  logic [N-1:0]    r_res [N];

  logic [CW-1:0]   w_pair;
  logic [N-1:0]    w_b1;
  logic [N-1:0]    w_b2;
  logic [N-1:0]    w_byte;
  logic [RW-1:0]   w_row;
  logic            w_unused;

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= StIdle;
    else          r_state <= w_state_d;
  end

  // Next-state logic
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:   if (i_start) w_state_d = StStream;
      StStream: if (r_cnt == CW'(2 * PAIRS - 1)) w_state_d = StRead;
      StRead:   if (r_cnt == CW'(N)) w_state_d = StDone;
      StDone:   w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  // Phase counter restarts at every state change; mode latches on the accepted start
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt    <= '0;
      r_usexor <= 1'b0;
    end else begin
      if (r_state != w_state_d) r_cnt <= '0;
      else if (r_state == StStream || r_state == StRead) r_cnt <= r_cnt + 1'b1;
      if (r_state == StIdle && i_start) r_usexor <= i_usexor_cfg;
    end
  end

  // Operand buffer: writable only while idle, never cleared
  always_ff @(posedge i_clk) begin
    if (i_rst_n && r_state == StIdle && i_wr_en) begin
      if (i_wr_addr[AW-1]) r_q[i_wr_addr[RW-1:0]] <= i_wr_data;
      else                 r_p[i_wr_addr[RW-1:0]] <= i_wr_data;
    end
  end

  // Row N-c is captured at the end of read cycle c (c = 1..N)
  assign w_row = RW'(CW'(N) - r_cnt);

  // Result buffer capture
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < N; i++) r_res[i] <= '0;
    end else if (r_state == StRead && r_cnt != '0) begin
      r_res[w_row] <= i_dev_uo_out[N-1:0];
    end
  end

  // Skew: lane j carries element s-j of its row during pair s
  assign w_pair = {1'b0, r_cnt[CW-1:1]};

  for (genvar j = 0; j < N; j++) begin : g_lane
    logic [CW-1:0] w_k;
    logic          w_valid;
    assign w_k     = w_pair - CW'(j);
    assign w_valid = (w_pair >= CW'(j)) && (w_k < CW'(N));
    assign w_b1[j] = w_valid & r_p[j][w_k[RW-1:0]];
    assign w_b2[j] = w_valid & r_q[j][w_k[RW-1:0]];
  end

  assign w_byte = r_cnt[0] ? w_b2 : w_b1;

  // Outputs decoded from state
  always_comb begin
    o_busy        = (r_state != StIdle);
    o_done        = (r_state == StDone);
    o_dev_readout = (r_state != StStream);
    o_dev_usexor  = r_usexor;
    o_dev_sayhi   = 1'b0;
    o_dev_ui_in   = '0;
    if (r_state == StStream) o_dev_ui_in[N-1:0] = w_byte;
  end

  assign o_rd_data = r_res[i_rd_addr];

  // Engine bits above N-1 are deliberately ignored
  assign w_unused = ^i_dev_uo_out;

endmodule

// File: tb/tb_sa_host_sequencer.sv
// Self-checking bench for sa_host_sequencer (N=8) with a behavioural engine model.
module tb_sa_host_sequencer;

  localparam int N = 8;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       usexor_cfg;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [2:0] rd_addr;
  logic [7:0] rd_data;
  logic       busy;
  logic       done;
  logic [7:0] dev_ui_in;
  logic       dev_readout;
  logic       dev_usexor;
  logic       dev_sayhi;
  logic [7:0] dev_uo_out;

  int checks;
  int failures;

  sa_host_sequencer #(.N(N)) u_dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_usexor_cfg (usexor_cfg),
    .i_wr_en      (wr_en),
    .i_wr_addr    (wr_addr),
    .i_wr_data    (wr_data),
    .i_rd_addr    (rd_addr),
    .o_rd_data    (rd_data),
    .o_busy       (busy),
    .o_done       (done),
    .o_dev_ui_in  (dev_ui_in),
    .o_dev_readout(dev_readout),
    .o_dev_usexor (dev_usexor),
    .o_dev_sayhi  (dev_sayhi),
    .i_dev_uo_out (dev_uo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // result[r] bit j = reduce_k (P[j][k] & Q[r][k])
  function automatic logic [7:0] ref_row(input logic [7:0][7:0] p, input logic [7:0][7:0] q,
                                         input logic x, input int r);
    logic [7:0] row;
    row = '0;
    for (int j = 0; j < N; j++) begin
      logic acc;
      acc = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (x) acc = acc ^ (p[j][k] & q[r][k]);
        else   acc = acc | (p[j][k] & q[r][k]);
      end
      row[j] = acc;
    end
    return row;
  endfunction

  // Engine model: rebuilds the matrices from the skewed stream, then presents
  // row N-c during read cycle c.
  logic [7:0][7:0] em_p, em_q;
  initial begin
    int  bidx;
    int  rc;
    logic prev_ro;
    dev_uo_out = '0;
    bidx = 0;
    rc = 0;
    prev_ro = 1'b1;
    em_p = '0;
    em_q = '0;
    forever begin
      @(negedge clk);
      if (!dev_readout) begin
        if (prev_ro) begin
          em_p = '0;
          em_q = '0;
          bidx = 0;
        end
        for (int j = 0; j < N; j++) begin
          int e;
          e = bidx / 2 - j;
          if (e >= 0 && e < N) begin
            if (bidx % 2 == 0) em_p[j][e] = dev_ui_in[j];
            else               em_q[j][e] = dev_ui_in[j];
          end
        end
        bidx++;
        rc = 0;
        dev_uo_out = '0;
      end else begin
        if (rc >= 1 && rc <= N) dev_uo_out = ref_row(em_p, em_q, dev_usexor, N - rc);
        else                    dev_uo_out = '0;
        if (rc < N + 2) rc++;
      end
      prev_ro = dev_readout;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  logic [7:0][7:0] cur_p, cur_q;

  task automatic load_ops(input logic [7:0][7:0] p, input logic [7:0][7:0] q);
    for (int a = 0; a < N; a++) begin
      wr_en = 1'b1; wr_addr = 4'(a); wr_data = p[a]; tick();
      wr_addr = 4'(N + a); wr_data = q[a]; tick();
    end
    wr_en = 1'b0;
    cur_p = p;
    cur_q = q;
  endtask

  logic [7:0] sb [0:80];
  logic       ro [0:80];
  logic       bz [0:80];
  logic       ux [0:80];

  // One operation; k counts cycles after the accepting edge. inj_* fire in cycle k.
  task automatic run_op(input logic mode, input int inj_start, input int inj_wr,
                        input int inj_rst, output int done_cnt, output int done_cyc);
    usexor_cfg = mode;
    start = 1'b1;
    tick();
    start = 1'b0;
    usexor_cfg = ~mode;
    done_cnt = 0;
    done_cyc = -1;
    for (int k = 1; k <= 80; k++) begin
      start   = (k == inj_start);
      wr_en   = (k == inj_wr);
      wr_addr = 4'd0;
      wr_data = 8'hA5;
      rst_n   = !(k == inj_rst);
      sb[k] = dev_ui_in;
      ro[k] = dev_readout;
      bz[k] = busy;
      ux[k] = dev_usexor;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = k;
      end
      tick();
    end
    start = 1'b0; wr_en = 1'b0; rst_n = 1'b1;
  endtask

  task automatic check_rows(input string tag, input logic [7:0][7:0] exp);
    for (int r = 0; r < N; r++) begin
      rd_addr = 3'(r);
      #1;
      chk($sformatf("%s_row%0d", tag, r), 32'(rd_data), 32'(exp[r]));
    end
  endtask

  typedef struct {
    logic [7:0][7:0] p;
    logic [7:0][7:0] q;
    logic            mode;
    logic [7:0][7:0] exp;
  } vec_t;

  vec_t vecs [4];

  initial begin
    logic [7:0][7:0] p, q, ident, zero, e;
    int dc, dy, nz;
    checks = 0;
    failures = 0;
    rst_n = 1'b0; start = 1'b0; usexor_cfg = 1'b0; wr_en = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr = '0;
    zero = '0;
    for (int k = 0; k < N; k++) ident[k] = 8'(1 << k);

    vecs[0] = '{p: ident,         q: ident,         mode: 1'b0, exp: ident};
    vecs[1] = '{p: {8{8'hFF}},    q: {8{8'h07}},    mode: 1'b0, exp: {8{8'hFF}}};
    vecs[2] = '{p: {8{8'hFF}},    q: {8{8'h07}},    mode: 1'b1, exp: {8{8'hFF}}};
    vecs[3] = '{p: {8{8'hFF}},    q: {8{8'hFF}},    mode: 1'b1, exp: {8{8'h00}}};

    // Reset
    tick(); tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_readout", 32'(dev_readout), 32'd1);
    chk("rst_ui_in", 32'(dev_ui_in), 32'd0);
    chk("rst_sayhi", 32'(dev_sayhi), 32'd0);
    chk("rst_usexor", 32'(dev_usexor), 32'd0);
    check_rows("rst", zero);
    rst_n = 1'b1;
    tick();

    // Stream encoding: single P bit
    p = '0; p[3] = 8'h04;
    load_ops(p, zero);
    run_op(1'b0, -1, -1, -1, dc, dy);
    chk("enc_p_c11", 32'(sb[11]), 32'h08);
    nz = 0;
    for (int k = 1; k <= 55; k++) if (k != 11 && sb[k] != 8'h00) nz++;
    chk("enc_p_others_zero", 32'(nz), 32'd0);
    chk("enc_ro_c1", 32'(ro[1]), 32'd0);
    chk("enc_ro_c46", 32'(ro[46]), 32'd0);
    chk("enc_ro_c47", 32'(ro[47]), 32'd1);
    chk("enc_busy_c1", 32'(bz[1]), 32'd1);
    chk("enc_busy_c56", 32'(bz[56]), 32'd1);
    chk("enc_busy_c57", 32'(bz[57]), 32'd0);
    chk("enc_done_cyc", 32'(dy), 32'd56);
    chk("enc_done_cnt", 32'(dc), 32'd1);

    // Stream encoding: single Q bit
    q = '0; q[0] = 8'h01;
    load_ops(zero, q);
    run_op(1'b0, -1, -1, -1, dc, dy);
    chk("enc_q_c2", 32'(sb[2]), 32'h01);
    chk("enc_q_c1", 32'(sb[1]), 32'h00);

    // Table-driven operand sets
    for (int v = 0; v < 4; v++) begin
      load_ops(vecs[v].p, vecs[v].q);
      run_op(vecs[v].mode, -1, -1, -1, dc, dy);
      chk($sformatf("vec%0d_done_cyc", v), 32'(dy), 32'd56);
      chk($sformatf("vec%0d_done_cnt", v), 32'(dc), 32'd1);
      chk($sformatf("vec%0d_usexor", v), 32'(ux[1]), 32'(vecs[v].mode));
      check_rows($sformatf("vec%0d", v), vecs[v].exp);
    end

    // Random operands against the reference rule
    for (int t = 0; t < 4; t++) begin
      logic m;
      for (int k = 0; k < N; k++) begin
        p[k] = 8'($urandom);
        q[k] = 8'($urandom);
      end
      m = 1'($urandom);
      load_ops(p, q);
      run_op(m, -1, -1, -1, dc, dy);
      for (int r = 0; r < N; r++) e[r] = ref_row(cur_p, cur_q, m, r);
      chk($sformatf("rnd%0d_done_cyc", t), 32'(dy), 32'd56);
      check_rows($sformatf("rnd%0d", t), e);
    end

    // Start and write while busy are ignored
    load_ops(ident, ident);
    run_op(1'b0, 10, 20, -1, dc, dy);
    chk("busy_done_cnt", 32'(dc), 32'd1);
    chk("busy_done_cyc", 32'(dy), 32'd56);
    check_rows("busy", ident);
    run_op(1'b0, -1, -1, -1, dc, dy);
    check_rows("busy_frozen", ident);

    // Reset in the middle of STREAM
    run_op(1'b1, -1, -1, 20, dc, dy);
    chk("mrst_ro_c21", 32'(ro[21]), 32'd1);
    chk("mrst_busy_c21", 32'(bz[21]), 32'd0);
    chk("mrst_no_done", 32'(dc), 32'd0);
    check_rows("mrst_cleared", zero);
    run_op(1'b0, -1, -1, -1, dc, dy);
    chk("mrst_fresh_done_cyc", 32'(dy), 32'd56);
    check_rows("mrst_fresh", ident);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sa_host_sequencer.md
Name: sa_host_sequencer

Overview:
- Host-side initiator for the bit-serial systolic matrix engine's ui_in/uio_in/uo_out protocol.
- Holds two N×N bit operand matrices loaded over a simple write port, and streams them to the engine as skewed byte pairs.
- Drives the readout sequence, captures the N result rows into a readable buffer, and signals done.
- Sits between a test/host controller and the engine's pins; used on-chip for self-test and in benches as the reference driver.

Parameters:
N, 8, array dimension; supported 2, 4, 8. Derived: PAIRS = 3N-1 stream pairs; AW = clog2(2N).

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
start  in  1  begin one multiply when idle
usexor_cfg  in  1  accumulate mode: 1=XOR, 0=OR; sampled at accepted start
wr_en  in  1  operand write strobe
wr_addr  in  AW  0..N-1 = P row j, N..2N-1 = Q row r
wr_data  in  N  operand row
rd_addr  in  clog2(N)  result row select
rd_data  out  N  result row, combinational read
busy  out  1  operation in progress
done  out  1  one-cycle completion pulse
dev_ui_in  out  8  engine data byte; bits above N-1 are 0
dev_readout  out  1  engine uio_in[1]
dev_usexor  out  1  engine uio_in[2]
dev_sayhi  out  1  engine uio_in[0]; constant 0
dev_uo_out  in  8  engine output byte; bits N-1:0 used

Behaviour:
- Reset (rst_n=0 at clk edge):
  - State IDLE; busy=0, done=0, dev_ui_in=0.
  - dev_readout=1, dev_usexor=0.
  - Result buffer cleared to 0. Operand buffer is not cleared.
- IDLE:
  - dev_readout is held at 1. This keeps the engine's accumulators cleared and its byte-pair phase aligned.
  - wr_en writes the operand buffer.
  - start=1 is accepted at the edge. It latches usexor_cfg into dev_usexor and enters STREAM.
  - If write and start occur in the same cycle, the write commits and the stream uses the new data.
- STREAM (2·PAIRS cycles; cycles 1..2·PAIRS after the accepting edge):
  - dev_readout=0.
  - Pair s (s=0..PAIRS-1) occupies cycles 2s+1 (byte1) and 2s+2 (byte2).
  - byte1 bit j = P[j][s-j] if 0 ≤ s-j < N, else 0.
  - byte2 bit i = Q[i][s-i] if 0 ≤ s-i < N, else 0.
  - Pairs s ≥ 2N-1 are all-zero flush pairs. They guarantee every in1 pipeline register is 0 before readout.
- READ (N+1 cycles; counter c=0..N):
  - dev_readout=1, dev_ui_in=0.
  - At the end of cycle c (c=1..N), dev_uo_out[N-1:0] is captured into result row N-c.
- DONE: done=1 for exactly one cycle in cycle 7N after the accepting edge (56 for N=8). Then return to IDLE.
- Resulting value: result[r] bit j = ⊕/∨ over k of (P[j][k] & Q[r][k]); XOR if the latched mode is 1, else OR.
- busy=1 from the cycle after acceptance through the DONE cycle inclusive.
- While busy:
  - start is ignored; wr_en is ignored (the operand buffer is frozen).
  - usexor_cfg changes have no effect.
- rd_data is always readable. During READ it reflects rows as they are captured; prior rows persist until overwritten.
- Reset mid-operation: returns to IDLE in the next cycle with dev_readout=1. No done pulse. Result buffer is cleared.
- Counters: stream cycle counter width clog2(2·PAIRS+1); no wrap within a run.

Test Plan:
- Reset: hold rst_n=0 two cycles → busy=0, done=0, dev_readout=1, dev_ui_in=0x00, dev_sayhi=0, rd_data=0 for all rows.
- Stream encoding, N=8:
  - Only P[3] = 0x04 (P[3][2]=1), Q=0, start → dev_ui_in=0x08 in cycle 11 (pair 5 byte1); all other stream bytes 0x00.
  - Only Q[0]=0x01 → byte2 of pair 0 (cycle 2) = 0x01.
- Identity, OR mode, against the engine model:
  - P[k]=Q[k]=1<<k → done exactly in cycle 56; result[r]=1<<r for r=0..7.
- Mode check:
  - P all 0xFF, Q all 0x07: OR → every result row = 0xFF.
  - Same operands, XOR → 0xFF (parity 3). Q all 0xFF with XOR → 0x00.
- Busy protection: start at cycle 10 and wr_en to addr 0 at cycle 20 while busy → ignored; the single done pulse and results match the original operands.
- Mid-run reset: rst_n=0 at cycle 20 of STREAM → next cycle dev_readout=1, busy=0, no done. A fresh start then yields the correct identity result with done 56 cycles later.
